// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480 timing constants, coordinate type and sprite placement
package vga_timing_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP = 33;
  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;
  // the sprite stage places its image with these, in the same x/y space
  localparam int SPRITE_X0 = 256;
  localparam int SPRITE_Y0 = 176;
  localparam int SPRITE_W = 128;
  localparam int SPRITE_H = 128;
  function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
    return v >= lo && v < hi;
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster coordinates, syncs and strobes from the timing generator
interface vga_timing_gen_if;
  import vga_timing_pkg::*;
  logic pixel_tick;
  coord_t x;
  coord_t y;
  logic video_on;
  logic hsync;
  logic vsync;
  logic line_start;
  logic frame_start;
  modport master(output pixel_tick, x, y, video_on, hsync, vsync, line_start, frame_start);
  modport slave(input pixel_tick, x, y, video_on, hsync, vsync, line_start, frame_start);
endinterface

// File: rtl/vga_timing_gen_pixel_tick_gen.sv
// pixel_tick_gen: clock-enable divider, one-clk tick every CLK_DIV clocks
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);
  localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
  logic [W-1:0] div;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
      tick <= 1'b0;
    end else begin
      div <= (div == LAST) ? '0 : div + 1'b1;
      tick <= (div == LAST);
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with registered sync/blank decode and optional delay line
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP = VGA_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int SYNC_DELAY = 0
) (
  input logic clk,
  input logic reset_n,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t HA = coord_t'(H_ACTIVE);
  localparam coord_t VA = coord_t'(V_ACTIVE);
  localparam coord_t HS0 = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS1 = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS0 = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS1 = coord_t'(V_ACTIVE + V_FP + V_SYNC);
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16 || SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_param
    $error("vga_timing_gen: CLK_DIV must be 1..16 and SYNC_DELAY 0..4");
  end
  logic tick, h_wrap, v_wrap, vid_raw, hs_raw, vs_raw;
  coord_t x_next, y_next;
  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .reset_n(reset_n), .tick(tick));
  assign vga.pixel_tick = tick;
  always_comb begin
    h_wrap = vga.x == H_LAST;
    v_wrap = h_wrap && vga.y == V_LAST;
    x_next = h_wrap ? '0 : vga.x + 1'b1;
    y_next = v_wrap ? '0 : (h_wrap ? vga.y + 1'b1 : vga.y);
  end
  // decode from the next-state counters so syncs move on the same edge as x/y
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga.x <= '0;
      vga.y <= '0;
      vid_raw <= 1'b0;
      hs_raw <= ~SYNC_POL;
      vs_raw <= ~SYNC_POL;
      vga.line_start <= 1'b0;
      vga.frame_start <= 1'b0;
    end else begin
      vga.line_start <= tick && h_wrap;
      vga.frame_start <= tick && v_wrap;
      if (tick) begin
        vga.x <= x_next;
        vga.y <= y_next;
        vid_raw <= x_next < HA && y_next < VA;
        hs_raw <= in_span(x_next, HS0, HS1) ? SYNC_POL : ~SYNC_POL;
        vs_raw <= in_span(y_next, VS0, VS1) ? SYNC_POL : ~SYNC_POL;
      end
    end
  end
  if (SYNC_DELAY == 0) begin : g_direct
    assign vga.video_on = vid_raw;
    assign vga.hsync = hs_raw;
    assign vga.vsync = vs_raw;
  end else begin : g_delay
    logic [SYNC_DELAY-1:0] vid_d, hs_d, vs_d;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vid_d <= '0;
        hs_d <= {SYNC_DELAY{~SYNC_POL}};
        vs_d <= {SYNC_DELAY{~SYNC_POL}};
      end else if (tick) begin
        vid_d <= SYNC_DELAY'({vid_d, vid_raw});
        hs_d <= SYNC_DELAY'({hs_d, hs_raw});
        vs_d <= SYNC_DELAY'({vs_d, vs_raw});
      end
    end
    assign vga.video_on = vid_d[SYNC_DELAY-1];
    assign vga.hsync = hs_d[SYNC_DELAY-1];
    assign vga.vsync = vs_d[SYNC_DELAY-1];
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed vector table plus hand sequences for reset, line and frame timing
module tb_vga_timing_gen;
  typedef struct {
    int s;
    int x;
    int y;
    logic vid;
    logic hs;
    logic vs;
  } vec_t;
  localparam logic [25:0] RST = {1'b0, 20'd0, 5'b01100};
  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int checks = 0;
  int failures = 0;
  vga_timing_gen_if ia ();
  vga_timing_gen_if ib ();
  vga_timing_gen_if ic ();
  vga_timing_gen ua (.clk(clk), .reset_n(rst_a), .vga(ia));
  vga_timing_gen #(.SYNC_DELAY(2)) uc (.clk(clk), .reset_n(rst_a), .vga(ic));
  // reduced raster: 24 x 15 at one clock per pixel, so whole frames fit in the run
  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) ub (.clk(clk), .reset_n(rst_b), .vga(ib));
  always #5 clk = ~clk;
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  function automatic logic [25:0] snap(input int s);
    case (s)
      0: snap = {ia.pixel_tick, ia.x, ia.y, ia.video_on, ia.hsync, ia.vsync, ia.line_start, ia.frame_start};
      1: snap = {ib.pixel_tick, ib.x, ib.y, ib.video_on, ib.hsync, ib.vsync, ib.line_start, ib.frame_start};
      default: snap = {ic.pixel_tick, ic.x, ic.y, ic.video_on, ic.hsync, ic.vsync, ic.line_start, ic.frame_start};
    endcase
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic wait_xy(input int s, input int tx, input int ty, input int budget, output bit ok);
    logic [25:0] v;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      v = snap(s);
      ok = int'(v[24:15]) == tx && int'(v[14:5]) == ty;
    end
  endtask
  initial begin
    vec_t vq[$];
    logic [25:0] v;
    bit ok;
    int n, lows, ymax;
    vq.push_back('{0, 20, 0, 1, 1, 1});
    vq.push_back('{0, 639, 0, 1, 1, 1});
    vq.push_back('{0, 640, 0, 0, 1, 1});
    vq.push_back('{2, 641, 0, 1, 1, 1});
    vq.push_back('{2, 642, 0, 0, 1, 1});
    vq.push_back('{0, 655, 0, 0, 1, 1});
    vq.push_back('{0, 656, 0, 0, 0, 1});
    vq.push_back('{2, 657, 0, 0, 1, 1});
    vq.push_back('{2, 658, 0, 0, 0, 1});
    vq.push_back('{0, 751, 0, 0, 0, 1});
    vq.push_back('{0, 752, 0, 0, 1, 1});
    vq.push_back('{2, 753, 0, 0, 0, 1});
    vq.push_back('{2, 754, 0, 0, 1, 1});
    vq.push_back('{0, 799, 0, 0, 1, 1});
    vq.push_back('{0, 0, 1, 1, 1, 1});
    vq.push_back('{2, 1, 1, 0, 1, 1});
    vq.push_back('{2, 2, 1, 1, 1, 1});
    vq.push_back('{1, 15, 7, 1, 1, 1});
    vq.push_back('{1, 16, 0, 0, 1, 1});
    vq.push_back('{1, 0, 8, 0, 1, 1});
    vq.push_back('{1, 23, 14, 0, 1, 1});
    vq.push_back('{1, 17, 3, 0, 1, 1});
    vq.push_back('{1, 18, 3, 0, 0, 1});
    vq.push_back('{1, 21, 3, 0, 0, 1});
    vq.push_back('{1, 22, 3, 0, 1, 1});
    vq.push_back('{1, 23, 9, 0, 1, 1});
    vq.push_back('{1, 0, 10, 0, 1, 0});
    vq.push_back('{1, 23, 11, 0, 1, 0});
    vq.push_back('{1, 0, 12, 0, 1, 1});
    vq.push_back('{1, 0, 0, 1, 1, 1});
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) chk($sformatf("rst_hold_s%0d_c%0d", s, k), int'(snap(s)), int'(RST));
    end
    rst_b = 1'b1;
    #1;
    chk("b_release_x", int'(ib.x), 0);
    chk("b_release_video_on", int'(ib.video_on), 0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ib.pixel_tick && n < 20);
    chk("b_first_tick_edge", n, 1);
    chk("b_pixel00_blank", int'(ib.video_on), 0);
    @(posedge clk);
    #1;
    chk("b_x_after_tick", int'(ib.x), 1);
    chk("b_video_on_x1", int'(ib.video_on), 1);
    n = 0;
    while (!ib.frame_start && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b_frame_start_seen", int'(ib.frame_start), 1);
    n = 0;
    lows = 0;
    ymax = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (ib.pixel_tick && !ib.vsync) lows++;
      if (int'(ib.y) > ymax) ymax = int'(ib.y);
    end while (!ib.frame_start && n < 1000);
    chk("b_frame_period", n, 360);
    chk("b_vsync_low_ticks", lows, 48);
    chk("b_y_max", ymax, 14);
    wait_xy(1, 10, 5, 1000, ok);
    chk("b_reach_mid", int'(ok), 1);
    rst_b = 1'b0;
    #1;
    chk("b_async_reset", int'(snap(1)), int'(RST));
    repeat (3) @(negedge clk);
    chk("b_reset_held", int'(snap(1)), int'(RST));
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("b_resume_x", int'(ib.x), 1);
    chk("b_resume_y", int'(ib.y), 0);
    @(negedge clk);
    rst_a = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ia.pixel_tick && n < 20);
    chk("a_first_tick_edge", n, 4);
    while (ia.x != 10 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("a_x10_edge", n, 41);
    chk("c_x_lockstep", int'(ic.x), 10);
    chk("c_y_lockstep", int'(ic.y), 0);
    foreach (vq[i]) begin
      wait_xy(vq[i].s, vq[i].x, vq[i].y, 4000, ok);
      v = snap(vq[i].s);
      chk($sformatf("vec%0d_reach", i), int'(ok), 1);
      chk($sformatf("vec%0d_video_on", i), int'(v[4]), int'(vq[i].vid));
      chk($sformatf("vec%0d_hsync", i), int'(v[3]), int'(vq[i].hs));
      chk($sformatf("vec%0d_vsync", i), int'(v[2]), int'(vq[i].vs));
    end
    n = 0;
    while (!ia.line_start && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("a_line_start_seen", int'(ia.line_start), 1);
    n = 0;
    lows = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (ia.pixel_tick && !ia.hsync) lows++;
    end while (!ia.line_start && n < 4000);
    chk("a_line_period", n, 3200);
    chk("a_hsync_low_ticks", lows, 96);
    chk("a_no_frame_start", int'(ia.frame_start), 0);
    @(posedge clk);
    #1;
    chk("a_line_start_width", int'(ia.line_start), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing from the 100 MHz system clock. Produces the pixel coordinates (x, y) consumed by the sprite/memory lookup stage, plus hsync, vsync, video_on and per-line/per-frame strobes. Sits directly upstream of the sprite stage and drives the board's VGA sync pins. The 4-bit RGB from the sprite stage is gated by video_on at the top level.

## Interface
Parameters:
- CLK_DIV, 4: system clocks per pixel (100 MHz / 4 = 25 MHz); legal 1..16
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing, in pixels
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing, in lines
- SYNC_POL, 0: asserted level of hsync/vsync (0 = active-low)
- SYNC_DELAY, 0: pixel ticks of delay on hsync/vsync/video_on relative to x/y; legal 0..4

Ports:
- clk  in  1  system clock, 100 MHz
- reset_n  in  1  asynchronous, active-low reset
- pixel_tick  out  1  one-clk pulse, once every CLK_DIV clocks
- x  out  10  current horizontal count, 0..H_TOTAL-1
- y  out  10  current vertical count, 0..V_TOTAL-1
- video_on  out  1  high while in the active region
- hsync  out  1  horizontal sync, polarity set by SYNC_POL
- vsync  out  1  vertical sync, polarity set by SYNC_POL
- line_start  out  1  one-clk pulse when x wraps to 0
- frame_start  out  1  one-clk pulse when x and y both wrap to 0

## Operation
- Totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Both must be ≤ 1024; enforce with an elaboration-time check.
- Divider: counter div runs 0..CLK_DIV-1. pixel_tick = (div == CLK_DIV-1). With CLK_DIV = 1, pixel_tick is constantly high after reset.
- Horizontal counter: on each pixel_tick, x advances by 1. When x = H_TOTAL-1, x wraps to 0.
- Vertical counter: y advances only on the tick on which x wraps. When y = V_TOTAL-1 at that wrap, y wraps to 0.
- All outputs are registered from the next-state counter values, so they change on the same edge as x/y and are mutually aligned.
- video_on = (x < H_ACTIVE) && (y < V_ACTIVE).
- hsync is asserted (== SYNC_POL) for H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC, i.e. x = 656..751.
- vsync is asserted for y = 490..491. vsync is line-granular: it changes only on the tick where x wraps to 0.
- line_start and frame_start are high for exactly one clk, coincident with the edge on which x (respectively x and y) become 0.
- SYNC_DELAY > 0: hsync, vsync and video_on each pass through a SYNC_DELAY-stage shift register that advances on pixel_tick. x, y and the strobes are not delayed. The shift register resets to the deasserted/blank state.

## Timing
- Reset values:
  - div = 0, x = 0, y = 0, pixel_tick = 0
  - video_on = 0
  - hsync = vsync = ~SYNC_POL
  - line_start = frame_start = 0
- Reset assertion is asynchronous and takes effect immediately, including mid-frame. Counters restart from (0,0) on release; no partial-line cleanup.
- After reset_n rises, the first pixel_tick occurs on the CLK_DIV-th rising edge.
- Pixel (0,0) of the first frame after reset is blanked (video_on stays 0 until the first tick). Every subsequent frame is normal.
- Line period = H_TOTAL ticks = 3200 clks. Frame period = 420000 ticks = 1,680,000 clks.
- Latency from x/y change to the matching sync/video_on change is 0 ticks, plus SYNC_DELAY ticks when SYNC_DELAY > 0.

## Structure
- Shared package vga_timing_pkg holds:
  - 640x480 timing constants and derived H_TOTAL/V_TOTAL
  - coordinate width (10)
  - the sprite stage's offset/size constants, so both stages agree on the coordinate space
- Sub-module pixel_tick_gen: parameterized clock-enable divider producing pixel_tick.
- Counters, decode and sync delay line live inline in vga_timing_gen.

## Test plan
- Reset: hold reset_n low 10 clks, then release. All outputs must hold their reset values while low. The first pixel_tick must appear on the 4th rising edge after release.
- Line timing: over one line, hsync is low for exactly 96 ticks, first low at x = 656 and high again at x = 752. line_start is spaced 3200 clks apart.
- Frame timing: vsync is low only for y = 490 and 491 (1600 ticks total). frame_start is spaced 1,680,000 clks apart. y never exceeds 524.
- Active region: video_on is high at (639,479) and low at (640,0), (0,480) and (799,524). video_on is high at (0,0) of the second frame.
- Mid-frame reset: assert reset_n at x = 300, y = 200 between clock edges. Outputs must go to reset values before the next edge. After release, counting resumes from (0,0).
- SYNC_DELAY = 2: hsync falls 2 ticks after x reaches 656. video_on falls when x = 642. x/y timing is unchanged from SYNC_DELAY = 0.
